tick_stopwatch: RTL and testbench
=================================

Name: tick_stopwatch

Overview:
- Downstream consumer of the 1 s terminal-count pulse from the 50 MHz counter/compare stage.
- Accumulates tick pulses into an MM:SS time kept as four BCD digits, with start/stop and clear control.
- Drives four seven-segment displays (HEX3..HEX0) and a running indicator LED on the DE2 board.
- Sits between the tick generator and the board's display/LED pins.

Parameters:
- MIN_LIMIT, 59, highest minute value before wrap-around; legal range 1..99.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (DE2 HEX displays), 0 = active-high.

Ports:
- clock  input  1  system clock (CLOCK_50)
- reset  input  1  synchronous, active-high reset
- tick  input  1  one-cycle pulse, one per second, from the terminal-count stage
- start_stop  input  1  one-cycle pulse; toggles between running and stopped
- clear  input  1  one-cycle pulse; zeroes the time and stops the count
- sec_ones  output  4  BCD seconds units, 0..9
- sec_tens  output  4  BCD seconds tens, 0..5
- min_ones  output  4  BCD minutes units, 0..9
- min_tens  output  4  BCD minutes tens, 0..9
- running  output  1  1 while in RUNNING
- wrap  output  1  one-cycle pulse on rollover from MIN_LIMIT:59 to 00:00
- hex0  output  7  segments for sec_ones, bit order g..a
- hex1  output  7  segments for sec_tens
- hex2  output  7  segments for min_ones
- hex3  output  7  segments for min_tens

Behaviour:
- FSM has two states, STOPPED and RUNNING. Reset state is STOPPED.
- Reset: all digits 0, running 0, wrap 0, every hex output shows "0" in the selected polarity.
  - SEG_ACTIVE_LOW=1: "0" is 7'b1000000.
- Control priority within one cycle: reset > clear > start_stop/tick.
- clear:
  - Sets all digits to 0 and the state to STOPPED at the next edge.
  - A tick or start_stop in the same cycle is ignored.
- start_stop:
  - Toggles the state at the next edge.
  - start_stop and tick in the same cycle: the tick is qualified by the pre-toggle state. A tick counts if the block was RUNNING before the edge.
- tick while STOPPED: ignored; digits hold.
- tick while RUNNING: digits advance by one second at the same edge (latency 0 cycles from the sampled tick).
- Increment rules:
  - sec_ones 9 -> 0 with carry into sec_tens.
  - sec_tens 5 -> 0 with carry into the minutes.
  - Minutes are treated as a 2-digit BCD value. At MIN_LIMIT:59 the next tick gives 00:00.
  - wrap is high for exactly the one cycle after the rollover edge, i.e. it is registered together with the digits.
- The state is unaffected by wrap: the block keeps RUNNING after a rollover.
- running is the registered state decode (RUNNING = 1).
- hex0..hex3:
  - Registered decode of the corresponding digit, one cycle after the digit changes.
  - Digits 0..9 use standard segment patterns.
  - A digit value above 9 is unreachable; if it occurs, all segments are off.
  - SEG_ACTIVE_LOW=0 inverts every pattern.
- Consecutive ticks are tolerated, including a tick every cycle: each is counted and there is no back-pressure.
- Reset or clear asserted mid-count discards the accumulated time; no partial carry persists.

Test Plan:
- Reset → all digits 0, running=0, wrap=0, hex0..hex3 = 7'b1000000. Then 1 start_stop pulse and 10 ticks → 00:10, running=1; hex0 = "0" pattern and hex1 = "1" pattern (7'b1111001) one cycle later.
- RUNNING at 00:59, 1 tick → 01:00. RUNNING at 09:59, 1 tick → 10:00. No wrap pulse in either case.
- MIN_LIMIT=59, RUNNING at 59:59, 1 tick → 00:00, wrap high for exactly 1 cycle, running stays 1. Repeat with MIN_LIMIT=2: 02:59 plus 1 tick → 00:00 with wrap.
- STOPPED at 00:07, 5 ticks → stays 00:07. Then start_stop and tick in the same cycle → 00:07 with running=1. Then start_stop and tick together while RUNNING → 00:08 with running=0.
- RUNNING at 03:42, clear, tick and start_stop all in the same cycle → 00:00, running=0. Reset asserted with a tick at 12:34 → 00:00 with every output at its reset value.
- Tick held high for 125 consecutive cycles while RUNNING from 00:00 → 02:05, with no dropped or double counts.

Source files
------------

// File: rtl/tick_stopwatch_if.sv
// Control pulses into, and BCD digits / segment patterns out of, the MM:SS stopwatch.
interface tick_stopwatch_if;
    logic       tick;
    logic       start_stop;
    logic       clear;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       wrap;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;

    modport master (
        output tick, start_stop, clear,
        input  sec_ones, sec_tens, min_ones, min_tens, running, wrap,
               hex0, hex1, hex2, hex3
    );

    modport slave (
        input  tick, start_stop, clear,
        output sec_ones, sec_tens, min_ones, min_tens, running, wrap,
               hex0, hex1, hex2, hex3
    );
endinterface

// File: rtl/tick_stopwatch.sv
// MM:SS stopwatch counting 1 s ticks in BCD, with start/stop, clear and
// registered seven-segment drive for four digits.
module tick_stopwatch #(
    parameter int MIN_LIMIT      = 59,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    tick_stopwatch_if.slave   bus
);

    typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

    localparam logic [3:0] LIM_TENS = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] LIM_ONES = 4'(MIN_LIMIT % 10);
    localparam logic [6:0] SEG_ZERO = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;

    // Active-high g..a pattern; out-of-range digits blank the display.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic       running_q, running_d;
    logic       wrap_q, wrap_d;
    logic [6:0] hex0_q, hex0_d;
    logic [6:0] hex1_q, hex1_d;
    logic [6:0] hex2_q, hex2_d;
    logic [6:0] hex3_q, hex3_d;

    logic tick_en;
    logic at_limit;

    // The tick is qualified by the state before any toggle in the same cycle.
    assign tick_en  = bus.tick && (state_q == RUNNING);
    assign at_limit = (min_tens_q == LIM_TENS) && (min_ones_q == LIM_ONES) &&
                      (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);

    always_comb begin
        state_d    = state_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        wrap_d     = 1'b0;

        if (bus.clear) begin
            state_d    = STOPPED;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
        end else begin
            if (bus.start_stop)
                state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
            if (tick_en) begin
                if (at_limit) begin
                    sec_ones_d = 4'd0;
                    sec_tens_d = 4'd0;
                    min_ones_d = 4'd0;
                    min_tens_d = 4'd0;
                    wrap_d     = 1'b1;
                end else if (sec_ones_q != 4'd9) begin
                    sec_ones_d = sec_ones_q + 4'd1;
                end else begin
                    sec_ones_d = 4'd0;
                    if (sec_tens_q != 4'd5) begin
                        sec_tens_d = sec_tens_q + 4'd1;
                    end else begin
                        sec_tens_d = 4'd0;
                        if (min_ones_q != 4'd9) begin
                            min_ones_d = min_ones_q + 4'd1;
                        end else begin
                            min_ones_d = 4'd0;
                            min_tens_d = min_tens_q + 4'd1;
                        end
                    end
                end
            end
        end

        running_d = (state_d == RUNNING);
        hex0_d    = seg_decode(sec_ones_q);
        hex1_d    = seg_decode(sec_tens_q);
        hex2_d    = seg_decode(min_ones_q);
        hex3_d    = seg_decode(min_tens_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= STOPPED;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
            hex0_q     <= SEG_ZERO;
            hex1_q     <= SEG_ZERO;
            hex2_q     <= SEG_ZERO;
            hex3_q     <= SEG_ZERO;
        end else begin
            state_q    <= state_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            running_q  <= running_d;
            wrap_q     <= wrap_d;
            hex0_q     <= hex0_d;
            hex1_q     <= hex1_d;
            hex2_q     <= hex2_d;
            hex3_q     <= hex3_d;
        end
    end

    assign bus.sec_ones = sec_ones_q;
    assign bus.sec_tens = sec_tens_q;
    assign bus.min_ones = min_ones_q;
    assign bus.min_tens = min_tens_q;
    assign bus.running  = running_q;
    assign bus.wrap     = wrap_q;
    assign bus.hex0     = hex0_q;
    assign bus.hex1     = hex1_q;
    assign bus.hex2     = hex2_q;
    assign bus.hex3     = hex3_q;

endmodule

// File: tb/tb_tick_stopwatch.sv
// Directed checks of tick_stopwatch: two instances, MIN_LIMIT=59 (a) and MIN_LIMIT=2 (b),
// fed identical control pulses.
module tb_tick_stopwatch;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0, start_stop = 1'b0, clear = 1'b0;
    int   n_chk = 0, n_err = 0;

    tick_stopwatch_if ia ();
    tick_stopwatch_if ib ();

    assign ia.tick = tick;  assign ia.start_stop = start_stop;  assign ia.clear = clear;
    assign ib.tick = tick;  assign ib.start_stop = start_stop;  assign ib.clear = clear;

    tick_stopwatch #(.MIN_LIMIT(59), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clock (clock), .reset (reset), .bus (ia.slave)
    );
    tick_stopwatch #(.MIN_LIMIT(2), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clock (clock), .reset (reset), .bus (ib.slave)
    );

    always #5 clock = ~clock;

    wire [15:0] time_a = {ia.min_tens, ia.min_ones, ia.sec_tens, ia.sec_ones};
    wire [15:0] time_b = {ib.min_tens, ib.min_ones, ib.sec_tens, ib.sec_ones};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given pulses; outputs are settled on return.
    task automatic cyc(input logic t, input logic s, input logic c);
        tick = t; start_stop = s; clear = c;
        @(posedge clock); #1;
        tick = 1'b0; start_stop = 1'b0; clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_time",    time_a, 16'h0000);
        chk("rst_running", ia.running, 1'b0);
        chk("rst_wrap",    ia.wrap, 1'b0);
        chk("rst_hex",     {ia.hex3, ia.hex2, ia.hex1, ia.hex0}, {4{7'h40}});
        reset = 1'b0;

        cyc(1'b0, 1'b1, 1'b0);
        chk("ss_running", ia.running, 1'b1);
        ticks(10);
        chk("t10_time", time_a, 16'h0010);
        chk("t10_hex0_lag", ia.hex0, 7'h10);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t10_hex0", ia.hex0, 7'h40);
        chk("t10_hex1", ia.hex1, 7'h79);

        ticks(49);
        chk("t59_time", time_a, 16'h0059);
        ticks(1);
        chk("min_carry_time", time_a, 16'h0100);
        chk("min_carry_wrap", ia.wrap, 1'b0);

        ticks(119);
        chk("b_259_time", time_b, 16'h0259);
        ticks(1);
        chk("a_300_time",  time_a, 16'h0300);
        chk("a_300_wrap",  ia.wrap, 1'b0);
        chk("b_wrap_time", time_b, 16'h0000);
        chk("b_wrap",      ib.wrap, 1'b1);
        chk("b_wrap_run",  ib.running, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("b_wrap_one", ib.wrap, 1'b0);

        ticks(419);
        chk("t959_time", time_a, 16'h0959);
        ticks(1);
        chk("tens_carry_time", time_a, 16'h1000);
        chk("tens_carry_wrap", ia.wrap, 1'b0);

        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(222);
        chk("t342_time", time_a, 16'h0342);
        cyc(1'b1, 1'b1, 1'b1);
        chk("clr_prio_time", time_a, 16'h0000);
        chk("clr_prio_run",  ia.running, 1'b0);

        cyc(1'b0, 1'b1, 1'b0);
        ticks(7);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(5);
        chk("stopped_hold", time_a, 16'h0007);
        chk("stopped_run",  ia.running, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("ss_tick_start_time", time_a, 16'h0007);
        chk("ss_tick_start_run",  ia.running, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("ss_tick_stop_time", time_a, 16'h0008);
        chk("ss_tick_stop_run",  ia.running, 1'b0);

        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(3599);
        chk("t5959_time", time_a, 16'h5959);
        ticks(1);
        chk("a_wrap_time", time_a, 16'h0000);
        chk("a_wrap",      ia.wrap, 1'b1);
        chk("a_wrap_run",  ia.running, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("a_wrap_one",  ia.wrap, 1'b0);
        chk("a_wrap_run2", ia.running, 1'b1);

        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(754);
        chk("t1234_time", time_a, 16'h1234);
        chk("t1234_hex3_lag", ia.hex3, 7'h79);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        chk("mid_rst_time", time_a, 16'h0000);
        chk("mid_rst_run",  ia.running, 1'b0);
        chk("mid_rst_wrap", ia.wrap, 1'b0);
        chk("mid_rst_hex",  {ia.hex3, ia.hex2, ia.hex1, ia.hex0}, {4{7'h40}});
        reset = 1'b0;

        cyc(1'b0, 1'b1, 1'b0);
        ticks(125);
        chk("burst_time", time_a, 16'h0205);
        cyc(1'b0, 1'b0, 1'b0);
        chk("burst_hex", {ia.hex3, ia.hex2, ia.hex1, ia.hex0},
            {7'h40, 7'h24, 7'h40, 7'h12});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
